pllcfg_cmd_sequencer: RTL and testbench
=======================================

// Module: pllcfg_cmd_sequencer
// PURPOSE
//  Sequences PLL-configuration commands from several FPGA-side requesters to the Nios CPU.
//  Drives the 3-bit command word polled by firmware and runs a level handshake on cpu_busy/cpu_done.
//  Round-robin shares the single CPU command channel, applies a timeout and returns per-requester status.
// PARAMETERS
//  N_REQ       4        number of requesters (1..8)
//  CMD_W       3        command width; must match the CPU input port
//  TIMEOUT_CYC 1048576  max cycles from issue to cpu_done; 0 disables the timeout
// PORTS
//  clk         in   1            system clock
//  reset_n     in   1            async reset, active low
//  req_valid   in   N_REQ        level; held until req_ack
//  req_cmd     in   N_REQ*CMD_W  command of requester i at [i*CMD_W +: CMD_W]
//  req_ack     out  N_REQ        1-cycle pulse: request accepted (granted)
//  req_done    out  N_REQ        1-cycle pulse: command finished
//  req_err     out  1            valid with any req_done bit: 1 = failed/timeout/illegal
//  cpu_cmd     out  CMD_W        to CPU PIO; 0 = no command pending
//  cpu_busy    in   1            from CPU: command picked up
//  cpu_done    in   1            from CPU, level: command finished
//  cpu_err     in   1            from CPU, sampled while cpu_done=1
//  busy        out  1            1 in any state other than IDLE
//  timeout_flg out  1            sticky; cleared by the next accepted request
// BEHAVIOUR
//  Reset: state IDLE; cpu_cmd=0; req_ack=0; req_done=0; req_err=0; busy=0; timeout_flg=0;
//   round-robin pointer=0. Asserting reset mid-command clears cpu_cmd immediately (async) and
//   aborts the command. No req_done is issued for the aborted command.
//  Inputs cpu_busy/cpu_done/cpu_err pass through a 2-flop synchroniser; all latencies below count
//   from the synchronised values.
//  Arbitration: in IDLE, grant the first req_valid at or after ptr (round-robin).
//   On grant, ptr <= grant+1 mod N_REQ.
//  FSM:
//   IDLE     any req_valid -> pulse req_ack[g]; latch g and cmd; clear timeout_flg.
//            If cmd==0: pulse req_done[g] with req_err=1 on the next cycle and stay IDLE (illegal).
//            Otherwise cpu_cmd<=cmd and go to ISSUE.
//   ISSUE    hold cpu_cmd. cpu_busy=1 -> WAIT_DONE. cpu_done=1 -> COMPLETE (fast CPU, busy skipped).
//   WAIT_DONE hold cpu_cmd. cpu_done=1 -> COMPLETE.
//   COMPLETE one cycle: latch cpu_err; cpu_cmd<=0; pulse req_done[g], req_err=cpu_err -> RELEASE.
//   RELEASE  cpu_cmd=0; wait until cpu_done=0 AND cpu_busy=0 -> IDLE.
//            Guarantees the CPU sees the idle command before the next issue.
//   TIMEOUT  entered from ISSUE/WAIT_DONE when the counter reaches TIMEOUT_CYC-1.
//            cpu_cmd<=0; timeout_flg<=1; pulse req_done[g] with req_err=1 -> RELEASE.
//  Timeout counter: clears on entering ISSUE, increments in ISSUE/WAIT_DONE, saturates.
//   Width = clog2(TIMEOUT_CYC+1).
//  Simultaneous events:
//   - cpu_done and timeout in the same cycle: cpu_done wins (COMPLETE).
//   - cpu_busy and cpu_done in the same cycle in ISSUE: COMPLETE.
//  req_valid dropped before ack: ignored, nothing is issued. A requester is never re-granted while
//   the FSM is not IDLE, so at most one command is outstanding.
//  Back-to-back requests: minimum IDLE->IDLE turnaround is 4 cycles plus the CPU latency.
//   A new grant is made in the cycle after RELEASE exits.
// STRUCTURE
//  pllcfg_pkg: command codes CMD_NONE=0, CMD_PLL_RECFG=1, CMD_PHASE_SRCH=2, CMD_PLL_RST=3,
//   CMD_RD_STAT=4; FSM state encodings.
//  Sub-module rr_arbiter (N_REQ, req, advance -> one-hot grant, ptr update) instantiated once;
//   the FSM, synchroniser and timeout counter are in this module.
// TESTING
//  1 req_valid=0010, cmd=1; CPU raises busy after 5 and done (err=0) after 20 -> req_ack[1] pulse,
//    cpu_cmd=1 until COMPLETE, req_done[1] with req_err=0, then cpu_cmd=0.
//  2 req_valid=1111 held, all cmd=2, ptr=0 -> grants in order 0,1,2,3; cpu_cmd returns to 0
//    between each; no overlap.
//  3 TIMEOUT_CYC=64; CPU never responds -> at issue+64 cpu_cmd=0, req_done with req_err=1,
//    timeout_flg=1; the next grant clears it.
//  4 CPU raises done with err=1 and no busy -> COMPLETE from ISSUE, req_err=1; RELEASE holds
//    until done=0.
//  5 req_cmd=0 on requester 2 -> req_ack[2], then req_done[2] with req_err=1 on the next cycle;
//    cpu_cmd stays 0.
//  6 reset_n low while in WAIT_DONE -> cpu_cmd=0 in the same cycle, no req_done; after release,
//    IDLE with ptr=0.

Source files
------------

// File: rtl/pllcfg_pkg.sv
// Shared definitions for the PLL-configuration command sequencer.
//  - Command codes understood by the Nios firmware (CMD_NONE means "no command pending").
//  - Sequencer FSM state encoding.
package pllcfg_pkg;

  localparam logic [2:0] CMD_NONE       = 3'd0;
  localparam logic [2:0] CMD_PLL_RECFG  = 3'd1;
  localparam logic [2:0] CMD_PHASE_SRCH = 3'd2;
  localparam logic [2:0] CMD_PLL_RST    = 3'd3;
  localparam logic [2:0] CMD_RD_STAT    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_COMPLETE  = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_TIMEOUT   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/pllcfg_cmd_sequencer_if.sv
// Bundle of requester-side and CPU-side signals of the command sequencer.
//  req_valid/req_cmd   requester -> sequencer (level request, command per requester)
//  req_ack/req_done    sequencer -> requester (1-cycle pulses), req_err qualifies req_done
//  cpu_cmd             sequencer -> CPU PIO (0 = idle)
//  cpu_busy/done/err   CPU -> sequencer (asynchronous to clk)
//  busy/timeout_flg    sequencer status
// slave  = the sequencer, master = the surrounding requesters and CPU.
interface pllcfg_cmd_sequencer_if #(
  parameter int N_REQ = 4,
  parameter int CMD_W = 3
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*CMD_W-1:0] req_cmd;
  logic [N_REQ-1:0]       req_ack;
  logic [N_REQ-1:0]       req_done;
  logic                   req_err;
  logic [CMD_W-1:0]       cpu_cmd;
  logic                   cpu_busy;
  logic                   cpu_done;
  logic                   cpu_err;
  logic                   busy;
  logic                   timeout_flg;

  modport master (
    output req_valid, req_cmd, cpu_busy, cpu_done, cpu_err,
    input  req_ack, req_done, req_err, cpu_cmd, busy, timeout_flg
  );

  modport slave (
    input  req_valid, req_cmd, cpu_busy, cpu_done, cpu_err,
    output req_ack, req_done, req_err, cpu_cmd, busy, timeout_flg
  );
endinterface

// File: rtl/pllcfg_cmd_sequencer_rr_arbiter.sv
// Round-robin arbiter for the sequencer's single CPU command channel.
//  clk, reset_n  clock / async active-low reset (pointer returns to 0)
//  req           request vector
//  advance       accept the current grant; pointer moves past the winner
//  grant         one-hot: first set req at or after the pointer (combinational)
module pllcfg_cmd_sequencer_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic [PTR_W:0]   sum;
  logic             found;

  // Scan from ptr upwards, wrapping at N_REQ (N_REQ need not be a power of two).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pllcfg_cmd_sequencer.sv
// Sequences PLL-configuration commands from N_REQ requesters to the Nios CPU.
//  clk, reset_n  clock / async active-low reset (aborts any command, cpu_cmd -> 0 at once)
//  bus (slave)   requester handshake (req_valid/req_cmd/req_ack/req_done/req_err),
//                CPU handshake (cpu_cmd out, cpu_busy/cpu_done/cpu_err in), busy, timeout_flg
// One command is outstanding at a time; the CPU handshake is a level handshake and the
// sequencer parks cpu_cmd at 0 until the CPU has dropped busy and done before the next issue.
module pllcfg_cmd_sequencer
  import pllcfg_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CMD_W       = 3,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pllcfg_cmd_sequencer_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  seq_state_e       state;
  logic [CMD_W-1:0] cpu_cmd_r;
  logic [N_REQ-1:0] req_ack_r;
  logic [N_REQ-1:0] req_done_r;
  logic             req_err_r;
  logic             timeout_flg_r;
  logic [N_REQ-1:0] owner;
  logic             illegal_pend;
  logic [CNT_W-1:0] tmo_cnt;

  logic cpu_busy_p0, cpu_busy_p1;
  logic cpu_done_p0, cpu_done_p1;
  logic cpu_err_p0,  cpu_err_p1;

  logic [N_REQ-1:0] grant_oh;
  logic             grant_en;
  logic [CMD_W-1:0] sel_cmd;

  // Synchroniser stage p0 -> p1 for the CPU-side handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_busy_p0 <= 1'b0;
      cpu_busy_p1 <= 1'b0;
      cpu_done_p0 <= 1'b0;
      cpu_done_p1 <= 1'b0;
    end else begin
      cpu_busy_p0 <= bus.cpu_busy;
      cpu_busy_p1 <= cpu_busy_p0;
      cpu_done_p0 <= bus.cpu_done;
      cpu_done_p1 <= cpu_done_p0;
    end
  end

  // cpu_err is only looked at while the synchronised done is high, so it needs no reset.
  always_ff @(posedge clk) begin
    cpu_err_p0 <= bus.cpu_err;
    cpu_err_p1 <= cpu_err_p0;
  end

  // No grant while an illegal-command done is still owed, so the requester has time to drop valid.
  assign grant_en = (state == ST_IDLE) && (|bus.req_valid) && !illegal_pend;

  pllcfg_cmd_sequencer_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req_valid),
    .advance (grant_en),
    .grant   (grant_oh)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) sel_cmd = bus.req_cmd[i*CMD_W +: CMD_W];
    end
  end

  // Completion outputs are produced on the transition into COMPLETE/TIMEOUT, so cpu_cmd
  // drops and req_done appears in the same cycle the FSM enters those states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cpu_cmd_r     <= '0;
      req_ack_r     <= '0;
      req_done_r    <= '0;
      req_err_r     <= 1'b0;
      timeout_flg_r <= 1'b0;
      owner         <= '0;
      illegal_pend  <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      req_ack_r  <= '0;
      req_done_r <= '0;
      req_err_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (illegal_pend) begin
            req_done_r   <= owner;
            req_err_r    <= 1'b1;
            illegal_pend <= 1'b0;
          end else if (grant_en) begin
            req_ack_r     <= grant_oh;
            owner         <= grant_oh;
            timeout_flg_r <= 1'b0;
            if (sel_cmd == CMD_W'(CMD_NONE)) begin
              illegal_pend <= 1'b1;
            end else begin
              cpu_cmd_r <= sel_cmd;
              tmo_cnt   <= '0;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE, ST_WAIT_DONE: begin
          // done has priority over both busy and the timeout.
          if (cpu_done_p1) begin
            cpu_cmd_r  <= '0;
            req_done_r <= owner;
            req_err_r  <= cpu_err_p1;
            state      <= ST_COMPLETE;
          end else if ((TIMEOUT_CYC != 0) && (tmo_cnt == CNT_LAST)) begin
            cpu_cmd_r     <= '0;
            req_done_r    <= owner;
            req_err_r     <= 1'b1;
            timeout_flg_r <= 1'b1;
            state         <= ST_TIMEOUT;
          end else begin
            if (tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if ((state == ST_ISSUE) && cpu_busy_p1) state <= ST_WAIT_DONE;
          end
        end
        ST_COMPLETE, ST_TIMEOUT: state <= ST_RELEASE;
        ST_RELEASE: begin
          if (!cpu_done_p1 && !cpu_busy_p1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_cmd     = cpu_cmd_r;
  assign bus.req_ack     = req_ack_r;
  assign bus.req_done    = req_done_r;
  assign bus.req_err     = req_err_r;
  assign bus.timeout_flg = timeout_flg_r;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_pllcfg_cmd_sequencer.sv
module tb_pllcfg_cmd_sequencer;
  import pllcfg_pkg::*;

  localparam int N_REQ       = 4;
  localparam int CMD_W       = 3;
  localparam int TIMEOUT_CYC = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pllcfg_cmd_sequencer_if #(.N_REQ(N_REQ), .CMD_W(CMD_W)) bus ();

  pllcfg_cmd_sequencer #(
    .N_REQ(N_REQ), .CMD_W(CMD_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests, their commands, round-robin pointer, sticky flag.
  logic [N_REQ-1:0] pending;
  logic [CMD_W-1:0] cmd_of [N_REQ];
  int               model_ptr;
  bit               tflg_model;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (model_ptr + k) % N_REQ;
      if (pending[i]) return i;
    end
    return 0;
  endfunction

  task automatic start_round(input logic [N_REQ-1:0] m, input logic [N_REQ*CMD_W-1:0] cv);
    for (int i = 0; i < N_REQ; i++) cmd_of[i] = cv[i*CMD_W +: CMD_W];
    pending       = m;
    bus.req_cmd   = cv;
    bus.req_valid = m;
  endtask

  // One transaction: mode bit0 = CPU raises busy at b_lat, bit1 = CPU raises done/err at d_lat
  // (cycles counted after the ack cycle); CPU keeps its lines for 'hold' cycles after req_done.
  task automatic run_one(input int mode, input int b_lat, input int d_lat, input bit err,
                         input int hold);
    int g, n, at, exp_at, k;
    bit timed, raised, cmd_ok;
    logic [CMD_W-1:0] c;
    g = model_pick();
    c = cmd_of[g];
    check_eq("tflg_sticky", 32'(bus.timeout_flg), 32'(tflg_model));
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ack == '0 && n < 8);
    check_eq("ack_lat", n, 1);
    check_eq("ack_grant", 32'(bus.req_ack), 32'(1) << g);
    check_eq("tflg_clr", 32'(bus.timeout_flg), 0);
    tflg_model = 1'b0;
    bus.req_valid[g] = 1'b0;
    pending[g] = 1'b0;
    model_ptr = (g + 1) % N_REQ;
    if (c == '0) begin
      check_eq("ill_cmd_ack", 32'(bus.cpu_cmd), 0);
      check_eq("ill_busy", 32'(bus.busy), 0);
      @(negedge clk);
      check_eq("ill_done", 32'(bus.req_done), 32'(1) << g);
      check_eq("ill_err", 32'(bus.req_err), 1);
      check_eq("ill_cmd_done", 32'(bus.cpu_cmd), 0);
      return;
    end
    check_eq("issue_cmd", 32'(bus.cpu_cmd), 32'(c));
    check_eq("issue_busy", 32'(bus.busy), 1);
    if (mode[1] && (d_lat + 3 <= TIMEOUT_CYC)) begin
      exp_at = d_lat + 3; timed = 1'b0;
    end else begin
      exp_at = TIMEOUT_CYC; timed = 1'b1;
    end
    at = 0;
    cmd_ok = 1'b1;
    for (int cyc = 1; cyc <= TIMEOUT_CYC + 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check_eq("ack_pulse", 32'(bus.req_ack), 0);
      if (bus.req_done != '0) begin at = cyc; break; end
      if (bus.cpu_cmd !== c) cmd_ok = 1'b0;
      if (mode[0] && cyc == b_lat) bus.cpu_busy = 1'b1;
      if (mode[1] && cyc == d_lat) begin bus.cpu_done = 1'b1; bus.cpu_err = err; end
    end
    check_eq("done_at", at, exp_at);
    check_eq("done_grant", 32'(bus.req_done), 32'(1) << g);
    check_eq("done_err", 32'(bus.req_err), timed ? 1 : 32'(err));
    check_eq("cmd_clr", 32'(bus.cpu_cmd), 0);
    check_eq("cmd_hold", 32'(cmd_ok), 1);
    check_eq("tflg_done", 32'(bus.timeout_flg), 32'(timed));
    tflg_model = timed;
    raised = bus.cpu_busy || bus.cpu_done;
    if (raised) repeat (hold) @(negedge clk);
    bus.cpu_busy = 1'b0;
    bus.cpu_done = 1'b0;
    bus.cpu_err  = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (bus.busy && k < 10);
    check_eq("release_lat", k, raised ? 3 : 2);
  endtask

  initial begin
    int n;
    bit seen;
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.cpu_busy  = 1'b0;
    bus.cpu_done  = 1'b0;
    bus.cpu_err   = 1'b0;
    pending    = '0;
    model_ptr  = 0;
    tflg_model = 1'b0;
    for (int i = 0; i < N_REQ; i++) cmd_of[i] = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_cpu_cmd", 32'(bus.cpu_cmd), 0);
    check_eq("rst_ack", 32'(bus.req_ack), 0);
    check_eq("rst_done", 32'(bus.req_done), 0);
    check_eq("rst_err", 32'(bus.req_err), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_tflg", 32'(bus.timeout_flg), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four requesting, round-robin from pointer 0.
    start_round(4'b1111, {4{CMD_PHASE_SRCH}});
    for (int i = 0; i < N_REQ; i++) run_one(3, 2, 6, 1'b0, 1);
    // Single requester 1, busy after 5, done after 20.
    start_round(4'b0010, {3'd0, 3'd0, CMD_PLL_RECFG, 3'd0});
    run_one(3, 5, 20, 1'b0, 2);
    // CPU never answers: timeout.
    start_round(4'b0001, {9'd0, CMD_RD_STAT});
    run_one(0, 0, 0, 1'b0, 0);
    // Illegal command on requester 2; its grant clears the sticky flag.
    start_round(4'b0100, 12'd0);
    run_one(0, 0, 0, 1'b0, 0);
    // Fast CPU: done with error, no busy, long done hold.
    start_round(4'b1000, {CMD_PLL_RST, 9'd0});
    run_one(2, 0, 10, 1'b1, 4);
    // done seen in the timeout cycle wins; one cycle later loses.
    start_round(4'b0001, {9'd0, CMD_PLL_RECFG});
    run_one(2, 0, 61, 1'b0, 0);
    start_round(4'b0010, {3'd0, 3'd0, CMD_PLL_RECFG, 3'd0});
    run_one(2, 0, 62, 1'b0, 0);
    // busy and done together; busy only then timeout.
    start_round(4'b0100, {3'd0, CMD_RD_STAT, 6'd0});
    run_one(3, 7, 7, 1'b1, 1);
    start_round(4'b1000, {CMD_PHASE_SRCH, 9'd0});
    run_one(1, 3, 0, 1'b0, 2);

    // Reset while the CPU is working on a command.
    start_round(4'b0010, {3'd0, 3'd0, CMD_PLL_RST, 3'd0});
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ack == '0 && n < 8);
    check_eq("rst6_ack", 32'(bus.req_ack), 32'b0010);
    bus.req_valid = '0;
    pending = '0;
    repeat (2) @(negedge clk);
    bus.cpu_busy = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("rst6_busy_pre", 32'(bus.busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst6_cmd_async", 32'(bus.cpu_cmd), 0);
    check_eq("rst6_busy", 32'(bus.busy), 0);
    bus.cpu_busy = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.req_done != '0) seen = 1'b1; end
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.req_done != '0) seen = 1'b1; end
    check_eq("rst6_no_done", 32'(seen), 0);
    model_ptr = 0;
    tflg_model = 1'b0;
    start_round(4'b1111, {CMD_PLL_RST, CMD_PHASE_SRCH, CMD_PLL_RECFG, CMD_NONE});
    run_one(3, 1, 4, 1'b0, 0);
    run_one(2, 0, 9, 1'b1, 0);
    run_one(3, 2, 3, 1'b0, 1);
    run_one(3, 4, 12, 1'b1, 0);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      logic [N_REQ-1:0]       m;
      logic [N_REQ*CMD_W-1:0] cv;
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      cv = '0;
      for (int i = 0; i < N_REQ; i++) cv[i*CMD_W +: CMD_W] = CMD_W'($urandom_range(0, 4));
      start_round(m, cv);
      while (pending != '0) begin
        int sel, md, b, d;
        sel = int'($urandom_range(0, 9));
        md = (sel <= 5) ? 3 : (sel <= 7) ? 2 : (sel == 8) ? 1 : 0;
        d = int'($urandom_range(1, 58));
        b = int'($urandom_range(1, d));
        run_one(md, b, d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
